// File: rtl/hpu_pkg.sv
// rtl/hpu_pkg.sv - shared node type, FSM states and pivot compare helpers
package hpu_pkg;

    localparam int HPU_DATA_W    = 32;
    localparam int HPU_ROW_IDX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } hpu_state_e;

    typedef struct packed {
        logic                            valid;
        logic [HPU_ROW_IDX_W-1:0]        row;
        logic signed [HPU_DATA_W-1:0]    val;
    } node_t;

    // Unsigned magnitude, so the most negative value maps to 2^(W-1) instead of overflowing.
    function automatic logic [HPU_DATA_W-1:0] hpu_abs(input logic signed [HPU_DATA_W-1:0] v);
        return v[HPU_DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic node_t hpu_better(input node_t a, input node_t b);
        logic [HPU_DATA_W-1:0] ma;
        logic [HPU_DATA_W-1:0] mb;
        ma = hpu_abs(a.val);
        mb = hpu_abs(b.val);
        if (!a.valid) return b;
        if (!b.valid) return a;
        if (ma != mb) return (ma > mb) ? a : b;
        return (a.row <= b.row) ? a : b;
    endfunction

endpackage

// File: rtl/hpu_pivot_tree_pipe.sv
// rtl/hpu_pivot_tree_pipe.sv - registered LANES-input pivot reduction tree, one register per level
module hpu_pivot_tree_pipe
    import hpu_pkg::*;
#(
    parameter int LANES = 8
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                beat_fire,
    input  node_t [LANES-1:0]   lane_nodes,
    output node_t               root,
    output logic                pipe_busy
);

    localparam int L = (LANES > 1) ? $clog2(LANES) : 0;

    // Stage 0 captures the masked beat; level k holds LANES>>k nodes, the rest stay invalid.
    node_t stg_q [0:L][0:LANES-1];
    node_t stg_d [0:L][0:LANES-1];

    always_comb begin
        for (int k = 0; k <= L; k++) begin
            for (int j = 0; j < LANES; j++) begin
                stg_d[k][j] = '0;
            end
        end
        for (int j = 0; j < LANES; j++) begin
            if (beat_fire) begin
                stg_d[0][j] = lane_nodes[j];
            end
        end
        for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < (LANES >> k); j++) begin
                stg_d[k][j] = hpu_better(stg_q[k-1][2*j], stg_q[k-1][2*j+1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= L; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    stg_q[k][j] <= '0;
                end
            end
        end else begin
            stg_q <= stg_d;
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k <= L; k++) begin
            for (int j = 0; j < LANES; j++) begin
                pipe_busy = pipe_busy | stg_q[k][j].valid;
            end
        end
    end

    assign root = stg_q[L][0];

endmodule

// File: rtl/hpu_pivot_stream.sv
// rtl/hpu_pivot_stream.sv - streaming pivot search top; HPU_PIVOT_SINGULAR_EN adds eps/pivot_singular
module hpu_pivot_stream
    import hpu_pkg::*;
#(
    parameter int DATA_W    = HPU_DATA_W,
    parameter int ROW_IDX_W = HPU_ROW_IDX_W,
    parameter int LANES     = 8,
    parameter int CNT_W     = 17
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_elems,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_W-1:0]       in_val,
    input  logic [LANES*ROW_IDX_W-1:0]    in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ROW_IDX_W-1:0]          pivot_row,
    output logic [DATA_W-1:0]             pivot_value,
    output logic                          pivot_found,
    output logic                          busy
`ifdef HPU_PIVOT_SINGULAR_EN
    ,
    input  logic [DATA_W-1:0]             eps,
    output logic                          pivot_singular
`endif
);

    hpu_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       num_q, num_d;
    node_t                  acc_q, acc_d;
    logic                   out_valid_q, out_valid_d;
    logic                   found_q, found_d;
    logic [ROW_IDX_W-1:0]   row_q, row_d;
    logic [DATA_W-1:0]      value_q, value_d;
`ifdef HPU_PIVOT_SINGULAR_EN
    logic [DATA_W-1:0]      eps_q, eps_d;
    logic                   singular_q, singular_d;
`endif

    node_t [LANES-1:0]      lane_nodes;
    node_t                  root;
    logic                   pipe_busy;
    logic                   beat_fire;
    logic [CNT_W:0]         cnt_sum;

    assign beat_fire = (state_q == ST_RUN) && in_valid;

    // Lanes past the end of the column are marked invalid so they can never win.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_nodes[i].val   = in_val[i*DATA_W +: DATA_W];
            lane_nodes[i].row   = in_row[i*ROW_IDX_W +: ROW_IDX_W];
            lane_nodes[i].valid = (({1'b0, cnt_q} + (CNT_W+1)'(i)) < {1'b0, num_q});
        end
    end

    hpu_pivot_tree_pipe #(
        .LANES      (LANES)
    ) u_tree (
        .clk        (clk),
        .rst        (rst),
        .beat_fire  (beat_fire),
        .lane_nodes (lane_nodes),
        .root       (root),
        .pipe_busy  (pipe_busy)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        found_d     = found_q;
        row_d       = row_q;
        value_d     = value_q;
`ifdef HPU_PIVOT_SINGULAR_EN
        eps_d       = eps_q;
        singular_d  = singular_q;
`endif
        cnt_sum     = {1'b0, cnt_q} + (CNT_W+1)'(LANES);

        if (root.valid) begin
            acc_d = hpu_better(acc_q, root);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d = num_elems;
                    cnt_d = '0;
                    acc_d = '0;
`ifdef HPU_PIVOT_SINGULAR_EN
                    eps_d = eps;
`endif
                    if (num_elems == '0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        found_d     = 1'b0;
                        row_d       = '0;
                        value_d     = '0;
`ifdef HPU_PIVOT_SINGULAR_EN
                        singular_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (beat_fire) begin
                    if (cnt_sum >= {1'b0, num_q}) begin
                        cnt_d   = num_q;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_sum[CNT_W-1:0];
                    end
                end
            end
            ST_DRAIN: begin
                // Empty pipeline means the root has already been folded into acc_q.
                if (!pipe_busy) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    found_d     = acc_q.valid;
                    row_d       = acc_q.row;
                    value_d     = acc_q.val;
`ifdef HPU_PIVOT_SINGULAR_EN
                    singular_d  = !acc_q.valid || (hpu_abs(acc_q.val) <= eps_q);
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            found_q     <= 1'b0;
            row_q       <= '0;
            value_q     <= '0;
`ifdef HPU_PIVOT_SINGULAR_EN
            eps_q       <= '0;
            singular_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            found_q     <= found_d;
            row_q       <= row_d;
            value_q     <= value_d;
`ifdef HPU_PIVOT_SINGULAR_EN
            eps_q       <= eps_d;
            singular_q  <= singular_d;
`endif
        end
    end

    assign in_ready    = (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = out_valid_q;
    assign pivot_found = found_q;
    assign pivot_row   = row_q;
    assign pivot_value = value_q;
`ifdef HPU_PIVOT_SINGULAR_EN
    assign pivot_singular = singular_q;
`endif

endmodule

// File: tb/tb_hpu_pivot_stream.sv
// tb/tb_hpu_pivot_stream.sv - table-driven bench for hpu_pivot_stream with LANES=4
module tb_hpu_pivot_stream;

    localparam int LANES     = 4;
    localparam int DATA_W    = 32;
    localparam int ROW_IDX_W = 16;
    localparam int CNT_W     = 17;
    localparam int LAT       = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [CNT_W-1:0]            num_elems;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_W-1:0]     in_val;
    logic [LANES*ROW_IDX_W-1:0]  in_row;
    logic                        out_valid;
    logic                        out_ready;
    logic [ROW_IDX_W-1:0]        pivot_row;
    logic [DATA_W-1:0]           pivot_value;
    logic                        pivot_found;
    logic                        busy;
`ifdef HPU_PIVOT_SINGULAR_EN
    logic [DATA_W-1:0]           eps;
    logic                        pivot_singular;
`endif

    always #5 clk = ~clk;

    hpu_pivot_stream #(
        .DATA_W      (DATA_W),
        .ROW_IDX_W   (ROW_IDX_W),
        .LANES       (LANES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_elems   (num_elems),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_val      (in_val),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pivot_row   (pivot_row),
        .pivot_value (pivot_value),
        .pivot_found (pivot_found),
        .busy        (busy)
`ifdef HPU_PIVOT_SINGULAR_EN
        ,
        .eps            (eps),
        .pivot_singular (pivot_singular)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Column data; each vector reads whole beats from its base, so entries past N are masked lanes.
    int pool [0:43] = '{
        3, -7, 2, 5, 7, 1, 0, -2, 4, 6, 0, 0,
        1, 2, -9, 3, 4, 1000, 1000, 1000,
        2147483647, -2147483647-1, 5, 2147483647,
        1, 2, 3, 4, 5, 6, -100, 999,
        5, -5, 5, -5,
        0, 0, 0, 77,
        2, -3, 1, 0
    };

    typedef struct {
        string name;
        int    n;
        int    base;
        bit    gaps;
        int    stall;
        int    exp_row;
        int    exp_val;
        bit    exp_found;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_search(input string nm, input int n, input int base, input bit gaps,
                              input int stall, input int exp_row, input int exp_val,
                              input bit exp_found);
        int     elem;
        int     k;
        int     iter;
        bit     took;
        bit     stable;
        longint r0;
        longint v0;
        longint f0;
        start     = 1'b1;
        num_elems = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) chk({nm, "_in_ready"}, in_ready, 0);
        elem = 0;
        iter = 0;
        while (elem < n && iter < 200) begin
            iter++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid  = 1'b0;
                start     = 1'b1;
                num_elems = CNT_W'(0);
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    in_val[i*DATA_W +: DATA_W]       = pool[base+elem+i];
                    in_row[i*ROW_IDX_W +: ROW_IDX_W] = ROW_IDX_W'(elem + i);
                end
            end
            took = in_valid && in_ready;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            if (took) elem += LANES;
        end
        chk({nm, "_beats_taken"}, (elem >= n), 1);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_latency"}, k, (n == 0) ? 0 : LAT);
        chk({nm, "_found"}, pivot_found, exp_found);
        chk({nm, "_row"}, pivot_row, exp_row);
        chk({nm, "_value"}, $signed(pivot_value), exp_val);
`ifdef HPU_PIVOT_SINGULAR_EN
        chk({nm, "_singular"}, pivot_singular,
            (!exp_found || ((exp_val < 0) ? -longint'(exp_val) : longint'(exp_val)) <= longint'(eps)) ? 1 : 0);
`endif
        r0 = pivot_row;
        v0 = pivot_value;
        f0 = pivot_found;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            num_elems = CNT_W'(5);
            @(posedge clk); #1;
            if (!(out_valid && pivot_row == r0 && pivot_value == v0 && pivot_found == f0)) stable = 1'b0;
        end
        if (stall > 0) chk({nm, "_stable_stall"}, stable, 1);
        // start coincides with the result handshake and must be dropped
        out_ready = 1'b1;
        start     = 1'b1;
        num_elems = CNT_W'(5);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk({nm, "_released_valid"}, out_valid, 0);
        chk({nm, "_released_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"tie_lower_row",  10,  0, 1'b0, 0, 1, -7,            1'b1};
        tbl[1] = '{"empty_column",    0,  0, 1'b0, 0, 0,  0,            1'b0};
        tbl[2] = '{"masked_tail",     5, 12, 1'b0, 0, 2, -9,            1'b1};
        tbl[3] = '{"gaps_and_stall", 10,  0, 1'b1, 5, 1, -7,            1'b1};
        tbl[4] = '{"most_negative",   4, 20, 1'b0, 0, 1, -2147483647-1, 1'b1};
        tbl[5] = '{"last_lane_wins",  7, 24, 1'b0, 0, 6, -100,          1'b1};
        tbl[6] = '{"all_equal_mag",   4, 32, 1'b0, 0, 0, 5,             1'b1};
        tbl[7] = '{"all_zero",        3, 36, 1'b0, 0, 0, 0,             1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        num_elems = '0;
        in_valid  = 1'b0;
        in_val    = '0;
        in_row    = '0;
        out_ready = 1'b0;
`ifdef HPU_PIVOT_SINGULAR_EN
        eps       = 3;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_found", pivot_found, 0);
        chk("rst_row", pivot_row, 0);
        chk("rst_value", pivot_value, 0);
`ifdef HPU_PIVOT_SINGULAR_EN
        chk("rst_singular", pivot_singular, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_search(tbl[v].name, tbl[v].n, tbl[v].base, tbl[v].gaps, tbl[v].stall,
                       tbl[v].exp_row, tbl[v].exp_val, tbl[v].exp_found);
        end

        // Reset in the middle of RUN must drop everything at once.
        start     = 1'b1;
        num_elems = CNT_W'(10);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            in_val[i*DATA_W +: DATA_W]       = pool[i];
            in_row[i*ROW_IDX_W +: ROW_IDX_W] = ROW_IDX_W'(i);
        end
        @(posedge clk); #1;
        chk("midrun_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_in_ready", in_ready, 0);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        run_search("after_reset", 3, 40, 1'b0, 0, 1, -3, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hpu_pivot_stream.md
# hpu_pivot_stream

Streaming, pipelined pivot-search unit for the HPU elimination datapath. It accepts a column of `num_elems` candidates as beats of `LANES` elements under a valid/ready handshake. It reduces each beat through a registered comparator tree and folds the beat winners into a running best. It then presents the winning (row, value) on a held output handshake. It is the sequential successor of the single-shot combinational pivot tree: buffer depth is decoupled from tree width, and long columns are handled without a 256-wide buffer.

## Interface
- `DATA_W`, 32, signed candidate value width
- `ROW_IDX_W`, 16, row index width
- `LANES`, 8, elements per beat; power of two, ≥1
- `CNT_W`, 17, width of `num_elems`; must cover `2^ROW_IDX_W`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a search; sampled only in IDLE
- `num_elems`  in  CNT_W  column length N; sampled with `start`
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_val`  in  LANES×DATA_W  signed lane values
- `in_row`  in  LANES×ROW_IDX_W  lane row indices
- `out_valid`  out  1  result valid, held until taken
- `out_ready`  in  1  result consumer ready
- `pivot_row`  out  ROW_IDX_W  winning row
- `pivot_value`  out  DATA_W  winning value (signed, not abs)
- `pivot_found`  out  1  0 iff N==0
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start` with N>0.
  - IDLE→DONE on `start` with N==0; result has found=0, row=0, value=0.
  - RUN→DRAIN on the edge that accepts the beat bringing the accepted count to ≥N.
  - DRAIN→DONE when the pipeline is empty.
  - DONE→IDLE on `out_valid & out_ready`.
- `in_ready` = (state==RUN). `in_ready` is low in all other states.
- Lane masking: lane i of a beat is valid iff accepted_count + i < N. accepted_count advances by LANES per accepted beat and saturates at N.
- Comparison rule, at every tree node and at the accumulator:
  - An invalid operand loses.
  - Otherwise the larger |val| wins. |val| is computed as a DATA_W-bit unsigned value, so |−2^(DATA_W−1)| = 2^(DATA_W−1).
  - On equal magnitude, the lower row index wins.
  - If both operands are invalid, the output is invalid.
- Accumulator: cleared to invalid on `start`. It is updated with the tree root when the root is valid.
- `start` is ignored while `busy`. A `start` in the same cycle as the DONE handshake is ignored.
- Outputs are registered and stay stable while `out_valid & !out_ready`.

## Timing
- Tree depth is L = log2(LANES), with one register per level.
- The accumulator is updated 1 cycle after the root register.
- If the final beat is accepted at edge t, `out_valid` is high from edge t+L+2.
  - LANES=8: 5 cycles.
  - LANES=1: 2 cycles.
- For N==0, `out_valid` is high at the edge after `start`.
- Throughput is one beat per cycle in RUN, with no bubbles under continuous `in_valid`.
- Reset values: state IDLE; `in_ready`, `out_valid`, `busy`, `pivot_found` = 0; `pivot_row`, `pivot_value` = 0; all pipeline valids = 0.
- Reset asserted mid-RUN/DRAIN/DONE: immediate return to IDLE, pending result discarded, no `out_valid` glitch.

## Configuration
- `HPU_PIVOT_SINGULAR_EN` defined:
  - Adds input `eps` (DATA_W, unsigned magnitude threshold, sampled with `start`).
  - Adds output `pivot_singular` = !found | (|pivot_value| ≤ eps).
  - `pivot_singular` is registered with the result and reset to 0.
- `HPU_PIVOT_SINGULAR_EN` undefined: neither port exists, and no threshold logic is built.

## Structure
- `hpu_pkg` holds:
  - `node_t` (val, row, valid)
  - the `hpu_better()` compare function (rule above)
  - the `hpu_abs()` magnitude function
  - the state enum
- Sub-module `hpu_pivot_tree_pipe` holds the LANES-input registered reduction tree, built from `hpu_better()`. The top level holds the FSM, the counter, lane masking, the accumulator and the output register.

## Test plan
- LANES=4, N=10, values [3,−7,2,5,7,1,0,−2,4,6], rows 0–9, continuous beats -> row 1, value −7 (tie vs 7 resolved to lower row), found=1, `out_valid` 4 cycles after the 3rd beat.
- N=0 `start` -> `out_valid` next cycle, found=0, row=0, value=0; `in_ready` never high.
- N=5, LANES=4, second beat lanes 1–3 = 1000 -> masked lanes ignored; winner taken from the first 5 elements only.
- Random `in_valid` gaps plus `out_ready` low for 5 cycles -> same result as the gapless run; outputs stable while stalled; `start` pulses while busy are ignored.
- Value −2^31 among positives up to 2^31−1 -> −2^31 wins.
- Reset asserted during RUN -> `busy`=0 and `out_valid`=0 immediately; a following N=3 search gives the correct result. With `HPU_PIVOT_SINGULAR_EN` defined, eps=3 and values [2,−3,1] -> `pivot_singular`=1.
